axi_stream_extract_header: RTL and testbench



---
 rtl/axis_hdr_pkg.sv | 29 ++
 rtl/axis_byte_realign.sv | 27 ++
 rtl/axi_stream_extract_header.sv | 170 +++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-mask helpers for the AXI-Stream header extractor.
package axis_hdr_pkg;

  typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

  localparam int unsigned B     = 4;
  localparam int unsigned MAX_B = 64;

  function automatic int unsigned keep2cnt(input logic [MAX_B-1:0] keep);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < MAX_B; i++) c += 32'(keep[i]);
    return c;
  endfunction

  // cnt ones placed at the top of an nb-bit mask
  function automatic logic [MAX_B-1:0] cnt2keep_msb(input int unsigned cnt, input int unsigned nb);
    logic [MAX_B-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < MAX_B; i++)
      if ((i < nb) && (i + cnt >= nb)) k[i] = 1'b1;
    return k;
  endfunction

  function automatic logic is_thermo(input logic [MAX_B-1:0] k);
    return (k != '0) && ((k & (k + MAX_B'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Funnel shifter: merges residual bytes with the top N bytes of the current beat.
module axis_byte_realign
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 8 * B,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic [DATA_WD-1:0]                  residual,
  input  logic [DATA_WD-1:0]                  data,
  input  logic [$clog2(DATA_BYTE_WD+1)-1:0]   n,
  output logic [DATA_WD-1:0]                  hdr_word,
  output logic [DATA_WD-1:0]                  merged,
  output logic [DATA_WD-1:0]                  new_res
);

  localparam int unsigned SH_W = $clog2(DATA_WD + 1);

  logic [SH_W-1:0] sh_n;
  logic [SH_W-1:0] sh_r;

  assign sh_n     = SH_W'(n) << 3;
  assign sh_r     = SH_W'(DATA_WD) - sh_n;
  assign hdr_word = data >> sh_r;
  assign merged   = residual | hdr_word;
  assign new_res  = data << sh_n;

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a 1..B byte header from an AXI-Stream packet and realigns the payload.
module axi_stream_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 8 * B,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [DATA_BYTE_WD-1:0] keep_strip,
  output logic                    ready_strip,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header,
  output logic                    err_out
);

  localparam int unsigned CNT_W = $clog2(DATA_BYTE_WD + 1);

  state_t                  state;
  logic [CNT_W-1:0]        n_q;
  logic [CNT_W-1:0]        flush_cnt_q;
  logic [DATA_BYTE_WD-1:0] strip_q;
  logic [DATA_WD-1:0]      residual_q;
  logic [DATA_WD-1:0]      data_m;
  logic [DATA_WD-1:0]      hdr_word;
  logic [DATA_WD-1:0]      merged;
  logic [DATA_WD-1:0]      new_res;
  logic [CNT_W-1:0]        k_in;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        strip_cnt;
  logic                    strip_legal;
  logic                    in_fire;
  logic                    out_free;

  function automatic logic [DATA_BYTE_WD-1:0] keep_msb(input logic [CNT_W-1:0] c);
    return DATA_BYTE_WD'(cnt2keep_msb(32'(c), DATA_BYTE_WD));
  endfunction

  // Unkept input bytes are zeroed so every derived word carries zeros there.
  always_comb begin
    data_m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
      data_m[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
  end

  assign k_in        = CNT_W'(keep2cnt(MAX_B'(keep_in)));
  assign strip_legal = is_thermo(MAX_B'(keep_strip));
  assign strip_cnt   = strip_legal ? CNT_W'(keep2cnt(MAX_B'(keep_strip))) : CNT_W'(DATA_BYTE_WD);
  assign r_cnt       = CNT_W'(DATA_BYTE_WD) - n_q;
  assign out_free    = !valid_out || ready_out;
  assign ready_strip = !rst && (state == IDLE);
  assign in_fire     = valid_in && ready_in;

  always_comb begin
    ready_in = 1'b0;
    if (!rst) begin
      case (state)
        HDR:     ready_in = (!valid_header || ready_header) && out_free;
        BODY:    ready_in = out_free;
        default: ready_in = 1'b0;
      endcase
    end
  end

  axis_byte_realign #(.DATA_WD(DATA_WD), .DATA_BYTE_WD(DATA_BYTE_WD)) u_realign (
    .residual (residual_q),
    .data     (data_m),
    .n        (n_q),
    .hdr_word (hdr_word),
    .merged   (merged),
    .new_res  (new_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n_q          <= '0;
      flush_cnt_q  <= '0;
      strip_q      <= '0;
      residual_q   <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
      valid_header <= 1'b0;
      header_out   <= '0;
      keep_header  <= '0;
      err_out      <= 1'b0;
    end else begin
      err_out <= 1'b0;
      if (ready_out)    valid_out    <= 1'b0;
      if (ready_header) valid_header <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_strip) begin
            n_q        <= strip_cnt;
            strip_q    <= keep_strip;
            err_out    <= !strip_legal;
            residual_q <= '0;
            state      <= HDR;
          end
        end
        HDR: begin
          if (in_fire) begin
            valid_header <= 1'b1;
            header_out   <= hdr_word;
            keep_header  <= strip_q;
            residual_q   <= new_res;
            if (!last_in) begin
              state <= BODY;
            end else begin
              state <= IDLE;
              if (k_in < n_q) begin
                err_out <= 1'b1;
              end else if (k_in > n_q) begin
                valid_out <= 1'b1;
                data_out  <= new_res;
                keep_out  <= keep_msb(k_in - n_q);
                last_out  <= 1'b1;
              end
            end
          end
        end
        BODY: begin
          if (in_fire) begin
            valid_out  <= 1'b1;
            data_out   <= merged;
            residual_q <= new_res;
            if (last_in && (k_in <= n_q)) begin
              keep_out <= keep_msb(r_cnt + k_in);
              last_out <= 1'b1;
              state    <= IDLE;
            end else begin
              keep_out <= '1;
              last_out <= 1'b0;
              if (last_in) begin
                flush_cnt_q <= k_in - n_q;
                state       <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= residual_q;
            keep_out  <= keep_msb(flush_cnt_q);
            last_out  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Self-checking bench: byte-level packet model vs. the header extractor.
module tb_axi_stream_extract_header;

  typedef byte unsigned bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_strip, ready_strip;
  logic [3:0]  keep_strip;
  logic        valid_header, ready_header;
  logic [31:0] header_out;
  logic [3:0]  keep_header;
  logic        err_out;

  always #5 clk = ~clk;

  axi_stream_extract_header #(.DATA_WD(32), .DATA_BYTE_WD(4)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_strip(valid_strip), .keep_strip(keep_strip), .ready_strip(ready_strip),
    .valid_header(valid_header), .header_out(header_out), .keep_header(keep_header), .ready_header(ready_header),
    .err_out(err_out)
  );

  int tests = 0;
  int fails = 0;
  int stall_viol = 0;
  int hdr_block_viol = 0;
  int err_cnt = 0;
  int err_base = 0;
  int exp_err = 0;
  int rdy_mode = 0;
  int hdr_hold = 0;

  logic [31:0] obs_data[$], exp_data[$], obs_hdr[$], exp_hdr[$];
  logic [3:0]  obs_keep[$], exp_keep[$], obs_hkeep[$], exp_hkeep[$];
  logic        obs_last[$], exp_last[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream and header-consumer ready generation, changed just after posedge.
  initial begin
    ready_out = 1'b1;
    ready_header = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       ready_out = 1'($urandom_range(0, 1));
        2:       ready_out = !ready_out;
        default: ready_out = 1'b1;
      endcase
      if (hdr_hold > 0) begin
        ready_header = 1'b0;
        hdr_hold--;
      end else begin
        ready_header = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Output monitor: collects transfers, counts error pulses, checks stall stability.
  logic        pv_o = 1'b0, pv_h = 1'b0;
  logic [36:0] pbeat = '0;
  logic [35:0] phdr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pv_o && (!valid_out || ({data_out, keep_out, last_out} !== pbeat))) stall_viol <= stall_viol + 1;
      if (pv_h && (!valid_header || ({header_out, keep_header} !== phdr))) stall_viol <= stall_viol + 1;
      if (valid_out && ready_out) begin
        obs_data.push_back(data_out);
        obs_keep.push_back(keep_out);
        obs_last.push_back(last_out);
      end
      if (valid_header && ready_header) begin
        obs_hdr.push_back(header_out);
        obs_hkeep.push_back(keep_header);
      end
      if (err_out) err_cnt <= err_cnt + 1;
    end
    pv_o  <= valid_out && !ready_out;
    pv_h  <= valid_header && !ready_header;
    pbeat <= {data_out, keep_out, last_out};
    phdr  <= {header_out, keep_header};
  end

  // Reference: header = first N bytes, payload = remaining bytes chunked by 4.
  task automatic add_expected(input logic [3:0] s, input bq_t pkt);
    int          n, len;
    logic        legal;
    logic [31:0] hdr, w;
    logic [3:0]  kp;
    legal = (s inside {4'b0001, 4'b0011, 4'b0111, 4'b1111});
    n     = legal ? $countones(s) : 4;
    len   = pkt.size();
    hdr   = '0;
    for (int i = 0; i < n; i++) hdr = (hdr << 8) | ((i < len) ? 32'(pkt[i]) : 32'h0);
    exp_hdr.push_back(hdr);
    exp_hkeep.push_back(s);
    exp_err += (legal ? 0 : 1) + ((len < n) ? 1 : 0);
    for (int p = n; p < len; p += 4) begin
      w = '0;
      kp = '0;
      for (int j = 0; j < 4; j++) begin
        w  = (w << 8) | ((p + j < len) ? 32'(pkt[p+j]) : 32'h0);
        kp = (kp << 1) | ((p + j < len) ? 4'h1 : 4'h0);
      end
      exp_data.push_back(w);
      exp_keep.push_back(kp);
      exp_last.push_back(p + 4 >= len);
    end
  endtask

  task automatic do_strip(input logic [3:0] s);
    logic got = 1'b0;
    valid_strip = 1'b1;
    keep_strip  = s;
    for (int c = 0; c < 300 && !got; c++) begin
      #1;
      if (ready_strip) got = 1'b1;
      @(negedge clk);
    end
    valid_strip = 1'b0;
    if (!got) check("strip_handshake_timeout", 64'(got), 64'd1);
  endtask

  task automatic put_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic first);
    logic got = 1'b0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    for (int c = 0; c < 300 && !got; c++) begin
      #1;
      if (first && ready_in && valid_header && !ready_header) hdr_block_viol++;
      if (ready_in) got = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    if (!got) check("beat_handshake_timeout", 64'(got), 64'd1);
  endtask

  task automatic send_pkt(input logic [3:0] s, input bq_t pkt);
    logic [31:0] d;
    logic [3:0]  k;
    int          len;
    len = pkt.size();
    add_expected(s, pkt);
    do_strip(s);
    for (int b = 0; b * 4 < len; b++) begin
      for (int j = 0; j < 4; j++) begin
        d[31-8*j -: 8] = (b*4 + j < len) ? pkt[b*4+j] : 8'($urandom);
        k[3-j]         = (b*4 + j < len);
      end
      put_beat(d, k, (b + 1) * 4 >= len, b == 0);
    end
  endtask

  task automatic clear_all();
    obs_data.delete(); obs_keep.delete(); obs_last.delete(); obs_hdr.delete(); obs_hkeep.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_hdr.delete(); exp_hkeep.delete();
    exp_err  = 0;
    err_base = err_cnt;
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (obs_data.size() >= exp_data.size() && obs_hdr.size() >= exp_hdr.size()) break;
    end
    repeat (4) @(posedge clk);
    check({tag, "_hdr_count"}, 64'(obs_hdr.size()), 64'(exp_hdr.size()));
    for (int i = 0; i < exp_hdr.size() && i < obs_hdr.size(); i++) begin
      check({tag, "_header_out"}, 64'(obs_hdr[i]), 64'(exp_hdr[i]));
      check({tag, "_keep_header"}, 64'(obs_hkeep[i]), 64'(exp_hkeep[i]));
    end
    check({tag, "_beat_count"}, 64'(obs_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      check({tag, "_data_out"}, 64'(obs_data[i]), 64'(exp_data[i]));
      check({tag, "_keep_out"}, 64'(obs_keep[i]), 64'(exp_keep[i]));
      check({tag, "_last_out"}, 64'(obs_last[i]), 64'(exp_last[i]));
    end
    check({tag, "_err_pulses"}, 64'(err_cnt - err_base), 64'(exp_err));
    clear_all();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t         pkt;
    logic [3:0]  s;
    int          len;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_strip = 1'b0; keep_strip = '0;
    repeat (3) @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_valid_header", 64'(valid_header), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd0);
    check("rst_ready_strip", 64'(ready_strip), 64'd0);
    check("rst_err_out", 64'(err_out), 64'd0);
    check("rst_last_out", 64'(last_out), 64'd0);
    check("rst_data_keep", 64'({data_out, keep_out}), 64'd0);
    check("rst_header_keep", 64'({header_out, keep_header}), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_ready_strip", 64'(ready_strip), 64'd1);
    @(negedge clk);
    clear_all();

    pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(4'b0011, pkt);
    check_all("n2_short_last");
    pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    send_pkt(4'b0011, pkt);
    check_all("n2_flush");
    pkt = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(4'b1111, pkt);
    check_all("n4_passthru");
    pkt = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt(4'b0111, pkt);
    check_all("n3_single");
    pkt = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    send_pkt(4'b0101, pkt);
    check_all("illegal_strip");
    pkt = {8'hC1, 8'hC2};
    send_pkt(4'b0111, pkt);
    check_all("short_header");

    // Header consumer stalled with toggling downstream: second HDR beat must wait.
    rdy_mode = 2;
    hdr_hold = 5;
    pkt = {8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(4'b0011, pkt);
    pkt = {8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    send_pkt(4'b0001, pkt);
    check_all("stall_toggle");
    rdy_mode = 0;

    // Reset in BODY aborts the packet without flushing.
    do_strip(4'b0011);
    put_beat(32'h11111111, 4'hF, 1'b0, 1'b1);
    put_beat(32'h22222222, 4'hF, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_valid_header", 64'(valid_header), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_idle_ready_strip", 64'(ready_strip), 64'd1);
    check("midrst_idle_ready_in", 64'(ready_in), 64'd0);
    @(negedge clk);
    clear_all();
    pkt = {8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    send_pkt(4'b0111, pkt);
    check_all("after_reset");

    // Randomized packets, two per check, random back-pressure.
    for (int t = 0; t < 30; t++) begin
      rdy_mode = (t % 3 == 0) ? 0 : 1;
      if (t % 7 == 3) hdr_hold = 4;
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 9))
          0, 1:    s = 4'b0001;
          2, 3:    s = 4'b0011;
          4, 5:    s = 4'b0111;
          6, 7:    s = 4'b1111;
          8:       s = 4'b0000;
          default: s = 4'($urandom_range(0, 15));
        endcase
        len = $urandom_range(1, 14);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
        send_pkt(s, pkt);
      end
      check_all("random");
    end
    rdy_mode = 0;

    repeat (5) @(negedge clk);
    check("stall_stability_violations", 64'(stall_viol), 64'd0);
    check("hdr_beat_accepted_while_header_stalled", 64'(hdr_block_viol), 64'd0);
    check("leftover_beats", 64'(obs_data.size() + obs_hdr.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
